fir_sequencer: RTL and testbench
================================

FIR_SEQUENCER -- requirements
Module: fir_sequencer

Interface
REQ-001 Parameter WIDTH, default 13, sample/coefficient width.
REQ-002 Parameter FLUSH_LEN, default 10, zero samples appended per frame (FIR delay depth).
REQ-003 Parameter TIMEOUT, default 255, max idle cycles in DRAIN before abort.
REQ-004 CLK  in  1  single clock, all logic rising-edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 S_DIN  in  WIDTH  source sample.
REQ-007 S_VALID  in  1  source sample valid.
REQ-008 S_LAST  in  1  marks last sample of frame, qualified by S_VALID.
REQ-009 S_READY  out  1  sequencer accepts sample this cycle.
REQ-010 CFG_WE  in  1  coefficient write strobe.
REQ-011 CFG_ADDR  in  4  coefficient index 0..10.
REQ-012 CFG_DATA  in  WIDTH  coefficient value.
REQ-013 H0..H10  out  WIDTH each  registered coefficients to FIR.
REQ-014 FIR_DIN  out  WIDTH  sample to FIR.
REQ-015 FIR_VIN  out  1  FIR input valid.
REQ-016 FIR_VOUT  in  1  FIR output valid.
REQ-017 BUSY  out  1  high in RUN, FLUSH, DRAIN.
REQ-018 FRAME_DONE  out  1  one-cycle pulse at frame end.
REQ-019 CFG_ERR  out  1  one-cycle pulse on rejected config write.
REQ-020 ERR_TO  out  1  sticky DRAIN timeout flag.
REQ-021 OUT_CNT  out  16  FIR_VOUT count in current frame.

Function
REQ-022 FSM states IDLE, RUN, FLUSH, DRAIN SHALL be the only states.
REQ-023 S_READY SHALL be 1 in IDLE and RUN, 0 in FLUSH and DRAIN; accept = S_VALID & S_READY.
REQ-024 Accepted sample SHALL appear on FIR_DIN with FIR_VIN=1 exactly one cycle later; FIR_VIN=0 otherwise outside FLUSH.
REQ-025 IDLE: accept without S_LAST -> RUN; accept with S_LAST -> FLUSH; accept clears OUT_CNT and input counter IN_CNT(16b) to 0 before counting this sample.
REQ-026 RUN: each accept increments IN_CNT (saturating at 0xFFFF); accept with S_LAST -> FLUSH.
REQ-027 FLUSH: FIR_DIN=0, FIR_VIN=1 for exactly FLUSH_LEN consecutive cycles, then -> DRAIN.
REQ-028 OUT_CNT SHALL increment (saturating) on every FIR_VOUT=1 while BUSY; ignored in IDLE.
REQ-029 DRAIN: when OUT_CNT reaches IN_CNT+FLUSH_LEN (counting a FIR_VOUT in the same cycle), pulse FRAME_DONE and -> IDLE.
REQ-030 DRAIN: cycle counter reset on each FIR_VOUT; reaching TIMEOUT cycles without FIR_VOUT SHALL set ERR_TO, pulse FRAME_DONE, -> IDLE.
REQ-031 Config write in IDLE with CFG_ADDR<=10 SHALL update H[CFG_ADDR] next cycle; simultaneous sample accept SHALL still occur and sees the new coefficient.
REQ-032 Config write in non-IDLE state or CFG_ADDR>10 SHALL be ignored and pulse CFG_ERR next cycle.
REQ-033 ERR_TO SHALL clear only on RST or on next frame start (IDLE accept).
REQ-034 FRAME_DONE, CFG_ERR SHALL be registered, never asserted two consecutive cycles.

Reset
REQ-035 RST=1 at a clock edge SHALL force IDLE, H0..H10=0, FIR_DIN=0, FIR_VIN=0, BUSY=0, FRAME_DONE=0, CFG_ERR=0, ERR_TO=0, OUT_CNT=0, IN_CNT=0, from any state including mid-frame.
REQ-036 S_READY SHALL be 0 while RST=1 and 1 in first cycle after RST deasserts.

Verification
REQ-037 Write H0..H10=1..11 in IDLE -> H outputs read 1..11; CFG_ADDR=12 write -> CFG_ERR pulse, H unchanged.
REQ-038 Frame of 5 samples 100..104, last on 104, FIR echoes VOUT 3 cycles after VIN -> FIR_DIN 100..104 then 10 zeros, FRAME_DONE once when OUT_CNT=15.
REQ-039 Single-sample frame (S_VALID+S_LAST in IDLE) -> one sample + 10 zeros, FRAME_DONE at OUT_CNT=11.
REQ-040 Source stalls (S_VALID gaps) in RUN -> FIR_VIN gaps match, no duplicated/lost samples.
REQ-041 FIR_VOUT held 0 in DRAIN -> ERR_TO=1 and FRAME_DONE after 255 cycles; next frame start clears ERR_TO.
REQ-042 RST asserted during FLUSH -> next cycle all outputs at reset values, state IDLE, S_READY=1 after release.

Source files
------------

// File: rtl/fir_sequencer.sv
// Frame sequencer in front of an 11-tap FIR: streams source samples, appends a
// zero flush tail, counts FIR outputs and holds the coefficient registers.
module fir_sequencer #(
  parameter int WIDTH     = 13,
  parameter int FLUSH_LEN = 10,
  parameter int TIMEOUT   = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] S_DIN,
  input  logic             S_VALID,
  input  logic             S_LAST,
  output logic             S_READY,
  input  logic             CFG_WE,
  input  logic [3:0]       CFG_ADDR,
  input  logic [WIDTH-1:0] CFG_DATA,
  output logic [WIDTH-1:0] H0,
  output logic [WIDTH-1:0] H1,
  output logic [WIDTH-1:0] H2,
  output logic [WIDTH-1:0] H3,
  output logic [WIDTH-1:0] H4,
  output logic [WIDTH-1:0] H5,
  output logic [WIDTH-1:0] H6,
  output logic [WIDTH-1:0] H7,
  output logic [WIDTH-1:0] H8,
  output logic [WIDTH-1:0] H9,
  output logic [WIDTH-1:0] H10,
  output logic [WIDTH-1:0] FIR_DIN,
  output logic             FIR_VIN,
  input  logic             FIR_VOUT,
  output logic             BUSY,
  output logic             FRAME_DONE,
  output logic             CFG_ERR,
  output logic             ERR_TO,
  output logic [15:0]      OUT_CNT
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] coef [0:10];
  logic             ready_q;
  logic [15:0]      in_cnt;
  logic [15:0]      flush_cnt;
  logic [15:0]      idle_cnt;
  logic             accept;
  logic             cfg_ok;
  logic [15:0]      out_cnt_inc;
  logic             flush_end;
  logic             drain_done;
  logic             drain_timeout;

  // Ready is gated by reset directly so it reads 0 for the whole reset pulse.
  assign S_READY = ready_q & ~RST;
  assign accept  = S_VALID & S_READY;
  assign cfg_ok  = (state == IDLE) && (CFG_ADDR <= 4'd10);

  assign H0  = coef[0];
  assign H1  = coef[1];
  assign H2  = coef[2];
  assign H3  = coef[3];
  assign H4  = coef[4];
  assign H5  = coef[5];
  assign H6  = coef[6];
  assign H7  = coef[7];
  assign H8  = coef[8];
  assign H9  = coef[9];
  assign H10 = coef[10];

  // Frame-end tests use the count including this cycle's FIR_VOUT.
  always_comb begin
    out_cnt_inc   = OUT_CNT;
    flush_end     = (flush_cnt == 16'(FLUSH_LEN - 1));
    drain_done    = 1'b0;
    drain_timeout = 1'b0;
    if (FIR_VOUT && (OUT_CNT != 16'hFFFF)) begin
      out_cnt_inc = OUT_CNT + 16'd1;
    end else begin
      out_cnt_inc = OUT_CNT;
    end
    drain_done    = ({1'b0, out_cnt_inc} >= ({1'b0, in_cnt} + 17'(FLUSH_LEN)));
    drain_timeout = !FIR_VOUT && (({1'b0, idle_cnt} + 17'd1) >= 17'(TIMEOUT));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = S_LAST ? FLUSH : RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (accept && S_LAST) begin
          state_nxt = FLUSH;
        end else begin
          state_nxt = RUN;
        end
      end
      FLUSH: begin
        if (flush_end) begin
          state_nxt = DRAIN;
        end else begin
          state_nxt = FLUSH;
        end
      end
      DRAIN: begin
        if (drain_done || drain_timeout) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DRAIN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      ready_q    <= 1'b1;
      BUSY       <= 1'b0;
      FIR_DIN    <= '0;
      FIR_VIN    <= 1'b0;
      in_cnt     <= 16'd0;
      OUT_CNT    <= 16'd0;
      flush_cnt  <= 16'd0;
      idle_cnt   <= 16'd0;
      FRAME_DONE <= 1'b0;
      CFG_ERR    <= 1'b0;
      ERR_TO     <= 1'b0;
      for (int i = 0; i < 11; i++) coef[i] <= '0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt == IDLE) || (state_nxt == RUN);
      BUSY    <= (state_nxt != IDLE);

      if (accept) begin
        FIR_DIN <= S_DIN;
        FIR_VIN <= 1'b1;
      end else if (state == FLUSH) begin
        FIR_DIN <= '0;
        FIR_VIN <= 1'b1;
      end else begin
        FIR_DIN <= '0;
        FIR_VIN <= 1'b0;
      end

      if (accept && (state == IDLE)) begin
        in_cnt <= 16'd1;
      end else if (accept && (in_cnt != 16'hFFFF)) begin
        in_cnt <= in_cnt + 16'd1;
      end else begin
        in_cnt <= in_cnt;
      end

      // A FIR_VOUT arriving in IDLE belongs to no frame and is dropped.
      if (accept && (state == IDLE)) begin
        OUT_CNT <= 16'd0;
      end else if (state != IDLE) begin
        OUT_CNT <= out_cnt_inc;
      end else begin
        OUT_CNT <= OUT_CNT;
      end

      flush_cnt <= (state == FLUSH) ? flush_cnt + 16'd1 : 16'd0;
      idle_cnt  <= ((state == DRAIN) && !FIR_VOUT) ? idle_cnt + 16'd1 : 16'd0;

      FRAME_DONE <= (state == DRAIN) && (drain_done || drain_timeout);

      if (accept && (state == IDLE)) begin
        ERR_TO <= 1'b0;
      end else if ((state == DRAIN) && !drain_done && drain_timeout) begin
        ERR_TO <= 1'b1;
      end else begin
        ERR_TO <= ERR_TO;
      end

      // Back-to-back rejects collapse so the error pulse never stretches.
      CFG_ERR <= CFG_WE && !cfg_ok && !CFG_ERR;
      for (int i = 0; i < 11; i++) begin
        if (CFG_WE && cfg_ok && (CFG_ADDR == 4'(i))) begin
          coef[i] <= CFG_DATA;
        end else begin
          coef[i] <= coef[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_sequencer.sv
// Self-checking bench for fir_sequencer: directed and randomized frames, a
// 3-cycle echo FIR model, configuration, timeout and mid-frame reset.
module tb_fir_sequencer;
  localparam int W  = 13;
  localparam int FL = 10;
  localparam int TO = 255;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] s_din = '0;
  logic         s_valid = 1'b0;
  logic         s_last = 1'b0;
  logic         s_ready;
  logic         cfg_we = 1'b0;
  logic [3:0]   cfg_addr = 4'd0;
  logic [W-1:0] cfg_data = '0;
  logic [W-1:0] h0, h1, h2, h3, h4, h5, h6, h7, h8, h9, h10;
  logic [W-1:0] fir_din;
  logic         fir_vin;
  logic         fir_vout = 1'b0;
  logic         busy, frame_done, cfg_err, err_to;
  logic [15:0]  out_cnt;

  int           n_tests = 0;
  int           n_fail = 0;
  logic [3:0]   pipe = 4'd0;
  bit           echo_en = 1'b1;
  logic [W-1:0] h_model [11];
  logic [W-1:0] got [$];
  logic [W-1:0] smp_q [$];
  int           fd_cnt = 0;
  int           tick_no = 0;
  int           last_vin_tick = 0;
  int           fd_tick = 0;
  logic         prev_fd = 1'b0;
  logic         prev_ce = 1'b0;
  logic [15:0]  out_at_done = 16'd0;

  fir_sequencer #(.WIDTH(W), .FLUSH_LEN(FL), .TIMEOUT(TO)) dut (
    .CLK(clk), .RST(rst), .S_DIN(s_din), .S_VALID(s_valid), .S_LAST(s_last),
    .S_READY(s_ready), .CFG_WE(cfg_we), .CFG_ADDR(cfg_addr), .CFG_DATA(cfg_data),
    .H0(h0), .H1(h1), .H2(h2), .H3(h3), .H4(h4), .H5(h5), .H6(h6), .H7(h7),
    .H8(h8), .H9(h9), .H10(h10), .FIR_DIN(fir_din), .FIR_VIN(fir_vin),
    .FIR_VOUT(fir_vout), .BUSY(busy), .FRAME_DONE(frame_done), .CFG_ERR(cfg_err),
    .ERR_TO(err_to), .OUT_CNT(out_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] hv(input int i);
    case (i)
      0: return h0;   1: return h1;   2: return h2;   3: return h3;
      4: return h4;   5: return h5;   6: return h6;   7: return h7;
      8: return h8;   9: return h9;   10: return h10;
      default: return 'x;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_h(input string tag);
    for (int i = 0; i < 11; i++) chk(tag, hv(i), h_model[i]);
  endtask

  // One clock; observe just after the edge and play the echo FIR (VOUT 3 cycles after VIN).
  task automatic tick();
    @(posedge clk);
    #1;
    tick_no++;
    chk("pulse_repeat", {30'd0, frame_done & prev_fd, cfg_err & prev_ce}, 32'd0);
    prev_fd = frame_done;
    prev_ce = cfg_err;
    if (fir_vin === 1'b1) begin
      got.push_back(fir_din);
      last_vin_tick = tick_no;
    end
    if (frame_done === 1'b1) begin
      fd_cnt++;
      out_at_done = out_cnt;
      fd_tick = tick_no;
    end
    pipe     = {pipe[2:0], fir_vin & echo_en};
    fir_vout = pipe[3];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    s_last = 1'b0;
    cfg_we = 1'b0;
    #1;
    chk("ready_in_rst", s_ready, 0);
    tick();
    pipe = 4'd0;
    fir_vout = 1'b0;
    for (int i = 0; i < 11; i++) h_model[i] = '0;
    chk("rst_busy", busy, 0);
    chk("rst_vin", fir_vin, 0);
    chk("rst_din", fir_din, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_err_to", err_to, 0);
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_ready", s_ready, 0);
    check_h("rst_h");
    rst = 1'b0;
    #1;
    chk("ready_after_rst", s_ready, 1);
  endtask

  // Streams smp_q as one frame; expected FIR stream is the samples followed by FL zeros.
  task automatic run_frame(input bit stalls, input bit echo, input bit cfg_busy);
    logic [W-1:0] exp_q [$];
    logic [W-1:0] newc;
    int  i;
    int  guard;
    bit  acc;
    got.delete();
    fd_cnt = 0;
    echo_en = echo;
    exp_q = smp_q;
    for (int k = 0; k < FL; k++) exp_q.push_back('0);
    i = 0;
    guard = 0;
    newc = W'($urandom);
    cfg_we = 1'b1;
    cfg_addr = 4'd10;
    cfg_data = newc;
    while (i < smp_q.size() && guard < 2000) begin
      guard++;
      s_valid = (guard == 1) ? 1'b1 : (stalls ? ($urandom_range(0, 3) != 0) : 1'b1);
      s_din = s_valid ? smp_q[i] : W'($urandom);
      s_last = (i == smp_q.size() - 1);
      chk("s_ready_open", s_ready, 1);
      acc = s_valid;
      tick();
      if (guard == 1) begin
        cfg_we = 1'b0;
        h_model[10] = newc;
        chk("h10_with_accept", h10, newc);
        chk("cfg_err_idle", cfg_err, 0);
        chk("err_to_cleared", err_to, 0);
        chk("out_cnt_cleared", out_cnt, 0);
      end
      chk("fir_vin", fir_vin, acc);
      if (acc) begin
        chk("fir_din", fir_din, smp_q[i]);
        i++;
      end
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    chk("ready_flush", s_ready, 0);
    chk("busy_flush", busy, 1);
    if (cfg_busy) begin
      cfg_we = 1'b1;
      cfg_addr = 4'd0;
      cfg_data = ~h_model[0];
      tick();
      cfg_we = 1'b0;
      chk("cfg_err_busy", cfg_err, 1);
      chk("h0_kept", h0, h_model[0]);
    end
    for (int k = 0; k < 600 && fd_cnt == 0; k++) tick();
    chk("frame_done_seen", fd_cnt, 1);
    chk("busy_after", busy, 0);
    chk("ready_after", s_ready, 1);
    chk("err_to", err_to, !echo);
    if (echo) chk("out_cnt_done", out_at_done, smp_q.size() + FL);
    else      chk("drain_len", fd_tick - last_vin_tick, TO);
    repeat (3) tick();
    chk("single_done", fd_cnt, 1);
    chk("err_to_sticky", err_to, !echo);
    chk("stream_len", got.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < got.size()) chk("stream", got[k], exp_q[k]);
    end
  endtask

  initial begin
    for (int i = 0; i < 11; i++) h_model[i] = '0;
    repeat (2) tick();
    do_reset();
    tick();

    // Coefficient load 1..11, then a rejected out-of-range write.
    for (int i = 0; i < 11; i++) begin
      cfg_we = 1'b1;
      cfg_addr = 4'(i);
      cfg_data = W'(i + 1);
      h_model[i] = W'(i + 1);
      tick();
      chk("cfg_err_ok", cfg_err, 0);
    end
    cfg_addr = 4'd12;
    cfg_data = 13'h1FFF;
    tick();
    cfg_we = 1'b0;
    chk("cfg_err_addr12", cfg_err, 1);
    tick();
    chk("cfg_err_pulse", cfg_err, 0);
    check_h("h_load");

    smp_q.delete();
    for (int i = 0; i < 5; i++) smp_q.push_back(W'(100 + i));
    run_frame(1'b0, 1'b1, 1'b0);

    smp_q.delete();
    smp_q.push_back(W'($urandom));
    run_frame(1'b0, 1'b1, 1'b1);

    smp_q.delete();
    for (int i = 0; i < 12; i++) smp_q.push_back(W'($urandom));
    run_frame(1'b1, 1'b1, 1'b0);

    smp_q.delete();
    for (int i = 0; i < 3; i++) smp_q.push_back(W'($urandom));
    run_frame(1'b1, 1'b0, 1'b0);

    smp_q.delete();
    for (int i = 0; i < 7; i++) smp_q.push_back(W'($urandom));
    run_frame(1'b1, 1'b1, 1'b0);

    // Reset while the flush tail is streaming.
    s_valid = 1'b1;
    s_last = 1'b1;
    s_din = 13'd7;
    tick();
    s_valid = 1'b0;
    s_last = 1'b0;
    repeat (2) tick();
    chk("busy_pre_rst", busy, 1);
    do_reset();
    tick();
    chk("idle_after_rst", busy, 0);

    smp_q.delete();
    for (int i = 0; i < 4; i++) smp_q.push_back(W'($urandom));
    run_frame(1'b1, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
